score_text_writer: RTL and testbench

SCORE_TEXT_WRITER -- requirements
Module: score_text_writer

---
 rtl/text_pkg.sv | 25 ++
 rtl/bcd_add3.sv | 9 +
 rtl/score_text_writer.sv | 154 +++++++++++++++
 tb/tb_score_text_writer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared character codes, default sizes and FSM state encoding for the score text writer.
package text_pkg;

    localparam logic [7:0] CHAR_BLANK = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    localparam int DEF_SCORE_W    = 16;
    localparam int DEF_NUM_DIGITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    // Power-on text is a lone '0' in the rightmost position, blank-padded or zero-padded.
    function automatic logic [7:0] reset_char(input int pos, input int num_digits, input bit blank);
        if (!blank || pos == num_digits - 1) begin
            return CHAR_ZERO;
        end
        return CHAR_BLANK;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble exceeds 4.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i > 4'd4) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/score_text_writer.sv
// Converts a binary score to right-aligned ASCII decimal text held in a double-buffered display.
// Handshake: a score transfers on a rising edge where score_valid && score_ready; score_ready is high only in IDLE.
module score_text_writer
    import text_pkg::*;
#(
    parameter int SCORE_W       = DEF_SCORE_W,
    parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    output logic               score_ready,
    input  logic [2:0]         rd_idx,
    output logic [7:0]         rd_char,
    output logic               busy,
    output logic               done,
    output state_e             dbg_state
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2((SCORE_W > NUM_DIGITS) ? SCORE_W : NUM_DIGITS) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic               lead_q, lead_d;
    logic               done_q, done_d;
    logic [7:0]         rd_char_q, rd_char_d;
    logic [7:0]         shadow_q  [NUM_DIGITS];
    logic [7:0]         shadow_d  [NUM_DIGITS];
    logic [7:0]         display_q [NUM_DIGITS];
    logic [7:0]         display_d [NUM_DIGITS];

    logic [3:0]         write_nib;
    logic               write_last;
    logic               write_blank;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        lead_d    = lead_q;
        done_d    = 1'b0;
        shadow_d  = shadow_q;
        display_d = display_q;

        // Digit slot cnt_q counts from the most significant nibble downwards.
        write_nib = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                write_nib = bcd_q[4*(NUM_DIGITS-1-i) +: 4];
            end
        end
        write_last  = (cnt_q == CNT_W'(NUM_DIGITS - 1));
        write_blank = BLANK_LEADING && lead_q && (write_nib == 4'd0) && !write_last;

        case (state_q)
            ST_IDLE: begin
                if (score_valid) begin
                    bin_d   = score;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                    cnt_d   = '0;
                    lead_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        shadow_d[i] = write_blank ? CHAR_BLANK : (CHAR_ZERO + {4'h0, write_nib});
                    end
                end
                if (write_nib != 4'd0) begin
                    lead_d = 1'b0;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (write_last) begin
                    cnt_d   = '0;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                display_d = shadow_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_char_d = CHAR_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_char_d = display_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            lead_q    <= 1'b1;
            done_q    <= 1'b0;
            rd_char_q <= CHAR_BLANK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i]  <= reset_char(i, NUM_DIGITS, BLANK_LEADING);
                display_q[i] <= reset_char(i, NUM_DIGITS, BLANK_LEADING);
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            lead_q    <= lead_d;
            done_q    <= done_d;
            rd_char_q <= rd_char_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
        end
    end

    assign score_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign rd_char     = rd_char_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_score_text_writer.sv
// Self-checking bench for score_text_writer: blanking and zero-padded instances, timing, hold-off, tear-free reads, reset abort.
module tb_score_text_writer;
    import text_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        score_valid;
    logic [15:0] score;
    logic        score_ready;
    logic [2:0]  rd_idx;
    logic [7:0]  rd_char;
    logic        busy;
    logic        done;
    state_e      dbg_state;

    logic        score_valid0;
    logic [15:0] score0;
    logic        score_ready0;
    logic [2:0]  rd_idx0;
    logic [7:0]  rd_char0;
    logic        busy0;
    logic        done0;
    state_e      dbg_state0;

    int checks   = 0;
    int failures = 0;
    logic [39:0] exp_q[$];

    score_text_writer #(.SCORE_W(16), .NUM_DIGITS(5), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .score_valid(score_valid), .score(score),
        .score_ready(score_ready), .rd_idx(rd_idx), .rd_char(rd_char),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    score_text_writer #(.SCORE_W(16), .NUM_DIGITS(5), .BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .score_valid(score_valid0), .score(score0),
        .score_ready(score_ready0), .rd_idx(rd_idx0), .rd_char(rd_char0),
        .busy(busy0), .done(done0), .dbg_state(dbg_state0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: decimal text by repeated division
    function automatic logic [39:0] model_text(input int v, input bit blank);
        logic [39:0] t;
        int d;
        int p;
        bit lead;
        t = '0;
        p = 10000;
        lead = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = (v / p) % 10;
            p = p / 10;
            if (blank && lead && d == 0 && i != 4) begin
                t[8*(4-i) +: 8] = 8'h20;
            end else begin
                t[8*(4-i) +: 8] = 8'(8'h30 + d);
                lead = 1'b0;
            end
        end
        return t;
    endfunction

    // driver tasks
    task automatic read_text(output logic [39:0] t);
        t = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_idx = 3'(i);
            @(negedge clk);
            t[8*(4-i) +: 8] = rd_char;
        end
    endtask

    task automatic read_text0(output logic [39:0] t);
        t = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_idx0 = 3'(i);
            @(negedge clk);
            t[8*(4-i) +: 8] = rd_char0;
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [39:0] zero_txt;
        logic [7:0]  exp_c;
        zero_txt = model_text(0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (score_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", score_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_char !== 8'h20) begin failures++; $display("FAIL reset_rd_char got=%h exp=20", rd_char); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_idx = 3'(i);
            @(negedge clk);
            exp_c = (i < 5) ? zero_txt[8*(4-i) +: 8] : 8'h20;
            checks++;
            if (rd_char !== exp_c) begin
                failures++; $display("FAIL reset_read idx=%0d got=%h exp=%h", i, rd_char, exp_c);
            end
        end
    endtask

    task automatic test_convert(input int v);
        logic [39:0] got, exp;
        int done_edge, done_cnt, busy_bad, t;
        @(negedge clk);
        score = 16'(v);
        score_valid = 1'b1;
        t = 0;
        while (!score_ready && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (!score_ready) begin failures++; $display("FAIL conv_ready_timeout val=%0d got=0 exp=1", v); end
        exp_q.push_back(model_text(v, 1'b1));
        @(negedge clk);
        score_valid = 1'b0;
        done_edge = 0; done_cnt = 0; busy_bad = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin done_cnt++; if (done_edge == 0) done_edge = k; end
            if (k <= 21 && (!busy || score_ready)) busy_bad++;
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL conv_done_count val=%0d got=%0d exp=1", v, done_cnt); end
        checks++; if (done_edge != 22) begin failures++; $display("FAIL conv_done_edge val=%0d got=%0d exp=22", v, done_edge); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL conv_busy val=%0d bad_cycles=%0d exp=0", v, busy_bad); end
        read_text(got);
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL conv_text val=%0d got=%h exp=<empty queue>", v, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin failures++; $display("FAIL conv_text val=%0d got=%h exp=%h", v, got, exp); end
        end
    endtask

    task automatic test_hold_off();
        logic [39:0] got, exp;
        int ready_bad, done_k, acc_k;
        bit seen;
        @(negedge clk);
        score = 16'd99;
        score_valid = 1'b1;
        exp_q.push_back(model_text(99, 1'b1));
        @(negedge clk);
        score = 16'd500;
        ready_bad = 0; done_k = 0; acc_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k <= 21 && score_ready) ready_bad++;
            if (done && done_k == 0) done_k = k;
            if (k > 22 && busy && acc_k == 0) begin
                acc_k = k;
                score_valid = 1'b0;
                exp_q.push_back(model_text(500, 1'b1));
            end
        end
        score_valid = 1'b0;
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL hold_ready_busy bad_cycles=%0d exp=0", ready_bad); end
        checks++; if (done_k != 22) begin failures++; $display("FAIL hold_done_edge got=%0d exp=22", done_k); end
        checks++; if (acc_k != 23) begin failures++; $display("FAIL hold_accept_edge got=%0d exp=23", acc_k); end
        read_text(got);
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if (got !== exp) begin failures++; $display("FAIL hold_text_99 got=%h exp=%h", got, exp); end
        wait_done(seen);
        checks++; if (!seen) begin failures++; $display("FAIL hold_done_500 got=0 exp=1"); end
        read_text(got);
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if (got !== exp) begin failures++; $display("FAIL hold_text_500 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_sweep();
        logic [39:0] old_txt, new_txt, exp;
        logic [7:0]  exp_c;
        int cur_idx, done_k;
        test_convert(99);
        old_txt = model_text(99, 1'b1);
        @(negedge clk);
        score = 16'd12345;
        score_valid = 1'b1;
        exp_q.push_back(model_text(12345, 1'b1));
        @(negedge clk);
        score_valid = 1'b0;
        cur_idx = 0;
        rd_idx = 3'd0;
        done_k = 0;
        new_txt = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done && done_k == 0) begin
                done_k = k;
                new_txt = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            end
            exp = (k >= 23) ? new_txt : old_txt;
            exp_c = exp[8*(4-cur_idx) +: 8];
            checks++;
            if (rd_char !== exp_c) begin
                failures++; $display("FAIL sweep_read edge=%0d idx=%0d got=%h exp=%h", k, cur_idx, rd_char, exp_c);
            end
            cur_idx = (cur_idx + 1) % 5;
            rd_idx = 3'(cur_idx);
        end
        checks++; if (done_k != 22) begin failures++; $display("FAIL sweep_done_edge got=%0d exp=22", done_k); end
    endtask

    task automatic test_no_blank();
        logic [39:0] got, exp;
        bit seen;
        exp = model_text(0, 1'b0);
        read_text0(got);
        checks++; if (got !== exp) begin failures++; $display("FAIL noblank_reset got=%h exp=%h", got, exp); end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            score0 = (n == 0) ? 16'd0 : 16'd305;
            score_valid0 = 1'b1;
            exp_q.push_back(model_text(int'(score0), 1'b0));
            @(negedge clk);
            score_valid0 = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                if (done0) seen = 1'b1;
            end
            checks++; if (!seen) begin failures++; $display("FAIL noblank_done n=%0d got=0 exp=1", n); end
            read_text0(got);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++; if (got !== exp) begin failures++; $display("FAIL noblank_text n=%0d got=%h exp=%h", n, got, exp); end
        end
    endtask

    task automatic test_reset_abort();
        logic [39:0] got, exp;
        int done_cnt;
        @(negedge clk);
        score = 16'd777;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (dbg_state !== ST_CONVERT) begin failures++; $display("FAIL abort_in_convert got=%0d exp=%0d", dbg_state, ST_CONVERT); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        checks++; if (score_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", score_ready); end
        exp = model_text(0, 1'b1);
        read_text(got);
        checks++; if (got !== exp) begin failures++; $display("FAIL abort_text got=%h exp=%h", got, exp); end
    endtask

    initial begin
        rst_n = 1'b0;
        score_valid = 1'b0; score = '0; rd_idx = '0;
        score_valid0 = 1'b0; score0 = '0; rd_idx0 = '0;
        test_reset();
        test_convert(1234);
        test_convert(65535);
        test_convert(0);
        for (int r = 0; r < 3; r++) test_convert(int'($urandom_range(0, 65535)));
        test_hold_off();
        test_sweep();
        test_no_blank();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
